// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ROM download-to-SDRAM programming path:
// the queued byte entry, the write FSM states and the byte-lane masks.
package jtframe_dwnld_pkg;

    typedef struct packed {
        logic        isProm;
        logic [24:0] addr;
        logic [7:0]  data;
    } dwnld_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } dwnld_state_t;

    // Active-low byte enables: bit0 = low lane, bit1 = high lane
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO that soaks up SDRAM stalls during a download.
// A push arriving together with a pop is always taken, even when full.
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  dwnld_entry_t din,
    output dwnld_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wrPtr_q;
    logic [AW:0]  rdPtr_q;
    dwnld_entry_t mem_q [DEPTH];
    logic         pushOk;
    logic         popOk;

    assign empty  = (wrPtr_q == rdPtr_q);
    assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign popOk  = pop & ~empty;
    assign pushOk = push & (~full | popOk);
    assign head   = mem_q[rdPtr_q[AW-1:0]];

    // Extra pointer MSB distinguishes full from empty when the indices match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (popOk)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtframe_dwnld_prog.sv
// Turns the I/O-controller byte download stream into masked SDRAM word writes,
// diverting the PROM region to a one-cycle BRAM strobe and holding busy until drained.
module jtframe_dwnld_prog
    import jtframe_dwnld_pkg::*;
#(
    parameter int          SDRAMW     = 22,
    parameter int          DEPTH      = 4,
    parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
    parameter bit          SWAB       = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [7:0]        prog_data,
    output logic [1:0]        prog_mask,
    output logic              prog_we,
    input  logic              prog_ack,
    input  logic              prog_rdy,
    output logic              prom_we,
    output logic              dwnld_busy,
    output logic              overflow
);

    dwnld_state_t      state_q, state_d;
    logic [SDRAMW-1:0] progAddr_q, progAddr_d;
    logic [7:0]        progData_q, progData_d;
    logic [1:0]        progMask_q, progMask_d;
    logic              progWe_q, progWe_d;
    logic              promWe_q, promWe_d;
    logic              overflow_q;
    logic              downloading_q;

    dwnld_entry_t pushEntry;
    dwnld_entry_t head;
    logic         pushReq;
    logic         fifoPop;
    logic         fifoFull;
    logic         fifoEmpty;
    logic         inProm;
    logic         laneHi;
    logic         unusedHeadBits;

    assign pushReq          = ioctl_wr & downloading;
    assign inProm           = (ioctl_addr >= PROM_START);
    assign pushEntry.isProm = inProm;
    assign pushEntry.addr   = inProm ? (ioctl_addr - PROM_START) : ioctl_addr;
    assign pushEntry.data   = ioctl_dout;
    assign laneHi           = head.addr[0] ^ SWAB;
    assign unusedHeadBits   = ^head.addr;

    jtframe_dwnld_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pushReq),
        .pop   (fifoPop),
        .din   (pushEntry),
        .head  (head),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // Write FSM: PROM bytes leave in one cycle, SDRAM bytes wait for ack then rdy before popping
    always_comb begin
        state_d    = state_q;
        progAddr_d = progAddr_q;
        progData_d = progData_q;
        progMask_d = progMask_q;
        progWe_d   = progWe_q;
        promWe_d   = 1'b0;
        fifoPop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    progData_d = head.data;
                    if (head.isProm) begin
                        progAddr_d = head.addr[SDRAMW-1:0];
                        promWe_d   = 1'b1;
                        fifoPop    = 1'b1;
                    end else begin
                        progAddr_d = head.addr[SDRAMW:1];
                        progMask_d = laneHi ? MASK_HI : MASK_LO;
                        progWe_d   = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (prog_ack) begin
                    progWe_d = 1'b0;
                    if (prog_rdy) begin
                        fifoPop    = 1'b1;
                        progMask_d = MASK_NONE;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (prog_rdy) begin
                    fifoPop    = 1'b1;
                    progMask_d = MASK_NONE;
                    state_d    = IDLE;
                end
            end
            default: begin
                progWe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            progAddr_q <= '0;
            progData_q <= '0;
            progMask_q <= MASK_NONE;
            progWe_q   <= 1'b0;
            promWe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            progAddr_q <= progAddr_d;
            progData_q <= progData_d;
            progMask_q <= progMask_d;
            progWe_q   <= progWe_d;
            promWe_q   <= promWe_d;
        end
    end

    // A drop wins over the clear so a byte lost on the first cycle of a new download is still flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q    <= 1'b0;
            downloading_q <= 1'b0;
        end else begin
            downloading_q <= downloading;
            if (pushReq && fifoFull && !fifoPop) begin
                overflow_q <= 1'b1;
            end else if (downloading && !downloading_q) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign prog_addr  = progAddr_q;
    assign prog_data  = progData_q;
    assign prog_mask  = progMask_q;
    assign prog_we    = progWe_q;
    assign prom_we    = promWe_q;
    assign overflow   = overflow_q;
    assign dwnld_busy = downloading | ~fifoEmpty | (state_q != IDLE);

endmodule

// File: tb/tb_jtframe_dwnld_prog.sv
// Directed bench for jtframe_dwnld_prog: lane mapping, PROM diversion,
// backpressure/overflow, push-on-pop while full and asynchronous reset.
module tb_jtframe_dwnld_prog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_ack = 1'b0;
    logic        prog_rdy = 1'b0;

    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_we;
    logic        dwnld_busy;
    logic        overflow;

    logic [21:0] swAddr;
    logic [7:0]  swData;
    logic [1:0]  swMask;
    logic        swWe;
    logic        swPromWe;
    logic        swBusy;
    logic        swOverflow;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    jtframe_dwnld_prog #(
        .SDRAMW(22), .DEPTH(4), .PROM_START(25'h100000), .SWAB(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .prom_we(prom_we), .dwnld_busy(dwnld_busy), .overflow(overflow)
    );

    jtframe_dwnld_prog #(
        .SDRAMW(22), .DEPTH(4), .PROM_START(25'h100000), .SWAB(1'b1)
    ) dutSwab (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .prog_addr(swAddr), .prog_data(swData), .prog_mask(swMask),
        .prog_we(swWe), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .prom_we(swPromWe), .dwnld_busy(swBusy), .overflow(swOverflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectorCount++; if (prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL reset_we: got %b want 0", prog_we); end
        vectorCount++; if (prom_we !== 1'b0) begin missCount++; $display("[TB] FAIL reset_prom_we: got %b want 0", prom_we); end
        vectorCount++; if (prog_mask !== 2'b11) begin missCount++; $display("[TB] FAIL reset_mask: got %b want 11", prog_mask); end
        vectorCount++; if (prog_addr !== 22'd0) begin missCount++; $display("[TB] FAIL reset_addr: got %h want 0", prog_addr); end
        vectorCount++; if (prog_data !== 8'h00) begin missCount++; $display("[TB] FAIL reset_data: got %h want 00", prog_data); end
        vectorCount++; if (dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy: got %b want 0", dwnld_busy); end
        vectorCount++; if (overflow !== 1'b0) begin missCount++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ignored_write();
        downloading = 1'b0;
        ioctl_addr = 25'h000005; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        vectorCount++; if (prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL ignored_we: got %b want 0", prog_we); end
        vectorCount++; if (dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL ignored_busy: got %b want 0", dwnld_busy); end
    endtask

    task automatic test_single_byte();
        downloading = 1'b1;
        ioctl_addr = 25'h000005; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0; downloading = 1'b0;
        tick();
        vectorCount++; if (prog_we !== 1'b1) begin missCount++; $display("[TB] FAIL single_we: got %b want 1", prog_we); end
        vectorCount++; if (prog_addr !== 22'd2) begin missCount++; $display("[TB] FAIL single_addr: got %h want 2", prog_addr); end
        vectorCount++; if (prog_mask !== 2'b01) begin missCount++; $display("[TB] FAIL single_mask: got %b want 01", prog_mask); end
        vectorCount++; if (prog_data !== 8'hA5) begin missCount++; $display("[TB] FAIL single_data: got %h want a5", prog_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectorCount++; if (prog_we !== 1'b1 || prog_addr !== 22'd2) begin missCount++; $display("[TB] FAIL single_hold: we=%b addr=%h want we=1 addr=2", prog_we, prog_addr); end
        end
        prog_ack = 1'b1;
        tick();
        prog_ack = 1'b0;
        vectorCount++; if (prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL single_we_after_ack: got %b want 0", prog_we); end
        vectorCount++; if (dwnld_busy !== 1'b1) begin missCount++; $display("[TB] FAIL single_busy_wait: got %b want 1", dwnld_busy); end
        tick();
        vectorCount++; if (dwnld_busy !== 1'b1) begin missCount++; $display("[TB] FAIL single_busy_wait2: got %b want 1", dwnld_busy); end
        prog_rdy = 1'b1;
        tick();
        prog_rdy = 1'b0;
        vectorCount++; if (dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL single_busy_done: got %b want 0", dwnld_busy); end
        vectorCount++; if (prog_mask !== 2'b11) begin missCount++; $display("[TB] FAIL single_mask_restore: got %b want 11", prog_mask); end
    endtask

    task automatic test_swab();
        downloading = 1'b1;
        ioctl_addr = 25'h000004; ioctl_dout = 8'h3C; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0; downloading = 1'b0;
        tick();
        vectorCount++; if (swWe !== 1'b1 || swAddr !== 22'd2) begin missCount++; $display("[TB] FAIL swab_req: we=%b addr=%h want we=1 addr=2", swWe, swAddr); end
        vectorCount++; if (swMask !== 2'b01) begin missCount++; $display("[TB] FAIL swab_mask: got %b want 01", swMask); end
        vectorCount++; if (prog_mask !== 2'b10) begin missCount++; $display("[TB] FAIL noswab_mask: got %b want 10", prog_mask); end
        prog_ack = 1'b1; prog_rdy = 1'b1;
        tick();
        prog_ack = 1'b0; prog_rdy = 1'b0;
        vectorCount++; if (dwnld_busy !== 1'b0 || swBusy !== 1'b0) begin missCount++; $display("[TB] FAIL swab_ackrdy_busy: got %b/%b want 0/0", dwnld_busy, swBusy); end
        vectorCount++; if (prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL swab_we_clear: got %b want 0", prog_we); end
    endtask

    task automatic test_prom();
        downloading = 1'b1;
        ioctl_addr = 25'h100000; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
        tick();
        ioctl_addr = 25'h100001; ioctl_dout = 8'h22;
        tick();
        ioctl_wr = 1'b0; downloading = 1'b0;
        vectorCount++; if (prom_we !== 1'b1 || prog_addr !== 22'd0 || prog_data !== 8'h11) begin missCount++; $display("[TB] FAIL prom_first: we=%b addr=%h data=%h want 1/0/11", prom_we, prog_addr, prog_data); end
        vectorCount++; if (prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL prom_first_sdram: got %b want 0", prog_we); end
        tick();
        vectorCount++; if (prom_we !== 1'b1 || prog_addr !== 22'd1 || prog_data !== 8'h22) begin missCount++; $display("[TB] FAIL prom_second: we=%b addr=%h data=%h want 1/1/22", prom_we, prog_addr, prog_data); end
        vectorCount++; if (prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL prom_second_sdram: got %b want 0", prog_we); end
        tick();
        vectorCount++; if (prom_we !== 1'b0 || prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL prom_end: prom_we=%b prog_we=%b want 0/0", prom_we, prog_we); end
        vectorCount++; if (dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL prom_busy: got %b want 0", dwnld_busy); end
    endtask

    task automatic test_backpressure();
        logic [21:0] expAddr [4] = '{22'h8, 22'h8, 22'h9, 22'h9};
        logic [1:0]  expMask [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [7:0]  expData [4] = '{8'h80, 8'h81, 8'h82, 8'h83};
        downloading = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ioctl_addr = 25'h10 + 25'(i); ioctl_dout = 8'h80 + 8'(i); ioctl_wr = 1'b1;
            tick();
            vectorCount++; if (overflow !== (i >= 4)) begin missCount++; $display("[TB] FAIL bp_overflow_%0d: got %b want %b", i, overflow, (i >= 4)); end
        end
        ioctl_wr = 1'b0;
        downloading = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            vectorCount++;
            if (prog_we !== 1'b1 || prog_addr !== expAddr[i] || prog_mask !== expMask[i] || prog_data !== expData[i]) begin
                missCount++;
                $display("[TB] FAIL bp_write_%0d: we=%b addr=%h mask=%b data=%h want 1/%h/%b/%h",
                         i, prog_we, prog_addr, prog_mask, prog_data, expAddr[i], expMask[i], expData[i]);
            end
            prog_ack = 1'b1; prog_rdy = 1'b1;
            tick();
            prog_ack = 1'b0; prog_rdy = 1'b0;
            tick();
        end
        tick();
        vectorCount++; if (prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL bp_extra_write: we=%b busy=%b want 0/0", prog_we, dwnld_busy); end
        vectorCount++; if (overflow !== 1'b1) begin missCount++; $display("[TB] FAIL bp_overflow_sticky: got %b want 1", overflow); end
        downloading = 1'b1;
        tick();
        vectorCount++; if (overflow !== 1'b0) begin missCount++; $display("[TB] FAIL bp_overflow_clear: got %b want 0", overflow); end
        downloading = 1'b0;
        tick();
    endtask

    task automatic test_push_on_pop_full();
        logic [21:0] expAddr [4] = '{22'h10, 22'h11, 22'h11, 22'h12};
        logic [1:0]  expMask [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0]  expData [4] = '{8'h91, 8'h92, 8'h93, 8'h94};
        downloading = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 25'h20 + 25'(i); ioctl_dout = 8'h90 + 8'(i); ioctl_wr = 1'b1;
            tick();
        end
        ioctl_addr = 25'h24; ioctl_dout = 8'h94; ioctl_wr = 1'b1;
        prog_ack = 1'b1; prog_rdy = 1'b1;
        tick();
        ioctl_wr = 1'b0; prog_ack = 1'b0; prog_rdy = 1'b0; downloading = 1'b0;
        vectorCount++; if (overflow !== 1'b0) begin missCount++; $display("[TB] FAIL pop_push_overflow: got %b want 0", overflow); end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectorCount++;
            if (prog_we !== 1'b1 || prog_addr !== expAddr[i] || prog_mask !== expMask[i] || prog_data !== expData[i]) begin
                missCount++;
                $display("[TB] FAIL pop_push_write_%0d: we=%b addr=%h mask=%b data=%h want 1/%h/%b/%h",
                         i, prog_we, prog_addr, prog_mask, prog_data, expAddr[i], expMask[i], expData[i]);
            end
            prog_ack = 1'b1; prog_rdy = 1'b1;
            tick();
            prog_ack = 1'b0; prog_rdy = 1'b0;
            tick();
        end
        vectorCount++; if (prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL pop_push_end: we=%b busy=%b want 0/0", prog_we, dwnld_busy); end
        vectorCount++; if (overflow !== 1'b0) begin missCount++; $display("[TB] FAIL pop_push_overflow_end: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid_req();
        downloading = 1'b1;
        ioctl_addr = 25'h30; ioctl_dout = 8'hA0; ioctl_wr = 1'b1;
        tick();
        ioctl_addr = 25'h31; ioctl_dout = 8'hA1;
        tick();
        ioctl_wr = 1'b0; downloading = 1'b0;
        vectorCount++; if (prog_we !== 1'b1 || dwnld_busy !== 1'b1) begin missCount++; $display("[TB] FAIL midreq_pre: we=%b busy=%b want 1/1", prog_we, dwnld_busy); end
        #2;
        rst = 1'b1;
        #1;
        vectorCount++; if (prog_we !== 1'b0) begin missCount++; $display("[TB] FAIL midreq_async_we: got %b want 0", prog_we); end
        vectorCount++; if (dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL midreq_async_busy: got %b want 0", dwnld_busy); end
        vectorCount++; if (prog_mask !== 2'b11) begin missCount++; $display("[TB] FAIL midreq_async_mask: got %b want 11", prog_mask); end
        tick();
        rst = 1'b0;
        prog_ack = 1'b1; prog_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectorCount++; if (prog_we !== 1'b0 || prom_we !== 1'b0) begin missCount++; $display("[TB] FAIL midreq_stale_%0d: we=%b prom_we=%b want 0/0", i, prog_we, prom_we); end
        end
        prog_ack = 1'b0; prog_rdy = 1'b0;
        vectorCount++; if (dwnld_busy !== 1'b0) begin missCount++; $display("[TB] FAIL midreq_busy_after: got %b want 0", dwnld_busy); end
    endtask

    initial begin
        $display("[TB] starting jtframe_dwnld_prog bench");
        test_reset();
        test_ignored_write();
        test_single_byte();
        test_swab();
        test_prom();
        test_backpressure();
        test_push_on_pop_full();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
